seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
Reverse path of the hex-to-seven-segment encoders. It samples the NUM_DIGITS active-low seven-segment buses driven to HEX7..HEX0 and waits for each pattern to be stable. It decodes each stable pattern back to a 4-bit nibble and assembles a NUM_DIGITS*4-bit word. It sits beside the LFSR_32bit display path as a self-check, so the value shown on the board can be compared against the LFSR state.

Parameters:
NUM_DIGITS, 8, number of seven-segment digits scanned; word width is NUM_DIGITS*4.
STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (min 1).
TIMEOUT_CYCLES, 1024, per-digit cycle limit before the digit is forced to error (used only with the optional feature).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low.
seg_bus  in  NUM_DIGITS*7  active-low segment patterns; digit i on [7i+6:7i], bit order [6:0] = g..a; digit 0 is the least-significant nibble.
start  in  1  single-cycle scan request.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when word and err_mask are final.
word  out  NUM_DIGITS*4  decoded value; nibble i at [4i+3:4i].
err_mask  out  NUM_DIGITS  bit i set when digit i was undecodable or timed out.

Behaviour:
- Reset values: busy=0, done=0, word=0, err_mask=0, FSM=IDLE, digit index=0, counters=0.
- Reset is asynchronous at any time, including mid-scan: the scan aborts and no done is issued.
- IDLE: start=1 clears word and err_mask, sets idx=0, and moves to SAMPLE. start while busy is ignored.
- SAMPLE:
  - Entry cycle loads prev=seg_bus[idx] and sets cnt=1.
  - Each following cycle: if seg_bus[idx]==prev, cnt increments; otherwise prev reloads and cnt=1.
  - When cnt reaches STABLE_CYCLES, the edge commits decode(prev) into nibble idx.
- After commit: if idx==NUM_DIGITS-1, go to DONE; otherwise idx increments and SAMPLE re-enters for the next digit.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. word and err_mask hold until the next accepted start.
- Latency with stable inputs: done is asserted NUM_DIGITS*STABLE_CYCLES+1 cycles after the start edge (33 with defaults).
- start in the DONE cycle is ignored.
- Decode table, pattern [6:0] -> nibble:
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7
  - 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F
- Any other pattern, including blank 0x7F, gives nibble 0 and sets err_mask[idx].
- Width rules: idx is $clog2(NUM_DIGITS) bits. cnt saturates at STABLE_CYCLES and never wraps.

Optional Feature:
SEG_SCAN_TIMEOUT_EN
- Defined: a per-digit counter runs from SAMPLE entry. If TIMEOUT_CYCLES elapse without commit, the digit gets nibble 0, err_mask[idx]=1, and the scan advances as after a normal commit.
  - If commit and timeout coincide, the commit wins.
- Undefined: no timeout counter. SAMPLE waits indefinitely for stability, and only reset exits.

Decomposition:
- Shared package seg7_pkg holds:
  - FSM state encoding (IDLE, SAMPLE, DONE);
  - segment constants SEG_0..SEG_F and SEG_BLANK;
  - the decode function returning {valid, nibble}.
- One natural sub-module, seg7_to_hex: combinational 7-bit -> {valid, 4-bit} lookup. It is instantiated once on prev.

Test Plan:
1. Static buses encoding 0xDEADBEEF, pulse start -> done 33 cycles later, word=0xDEADBEEF, err_mask=0x00.
2. Digit 3 toggles 0x79/0x24 for 10 cycles, then holds 0x24; rest encode 0 -> commit of digit 3 is delayed by the toggle time, word=0x00002000, err_mask=0x00.
3. Digit 5 held at 0x7F, others encode 1 -> word=0x11011111, err_mask=0x20.
4. start re-pulsed while busy, then rst_n low mid-scan -> no second scan; busy=0, word=0, done never pulses; a new start after release scans normally.
5. With SEG_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=16, digit 0 toggling every cycle, others encode 7 -> done pulses, word=0x77777770, err_mask=0x01.
6. Without SEG_SCAN_TIMEOUT_EN, same stimulus as 5 -> busy stays 1 while toggling; once digit 0 holds 0x40, word=0x77777770, err_mask=0x00.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: scan FSM encoding,
// active-low segment constants (bit order [6:0] = g..a) and the pattern decoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSample = 2'd1,
    StDone   = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg_decode_t;

  // Unknown patterns (blank included) decode to nibble 0 with valid cleared.
  function automatic seg_decode_t seg7_decode(input logic [6:0] seg);
    seg_decode_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    case (seg)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment (active-low, g..a) to {valid, nibble} lookup.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  seg_decode_t dec;

  // Table lookup through the shared package decoder.
  always_comb begin
    dec = seg7_decode(seg_i);
  end

  assign valid_o  = dec.valid;
  assign nibble_o = dec.nibble;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scans NUM_DIGITS active-low seven-segment buses one digit at a time, waits for
// STABLE_CYCLES identical samples, and decodes each digit into a nibble of word_o.
// Optional per-digit timeout is compiled in with the SEG_SCAN_TIMEOUT_EN macro.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_DIGITS*7-1:0] seg_bus_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NUM_DIGITS*4-1:0] word_o,
  output logic [NUM_DIGITS-1:0]   err_mask_o
);

  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned StableMin = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
  localparam int unsigned CntW      = $clog2(StableMin + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(StableMin);

  scan_state_e               state_q;
  logic [IdxW-1:0]           idx_q;
  logic [6:0]                prev_q;
  logic [CntW-1:0]           cnt_q;
  logic                      entry_q;
  logic                      busy_q;
  logic                      done_q;
  logic [NUM_DIGITS*4-1:0]   word_q;
  logic [NUM_DIGITS-1:0]     err_q;

  logic [6:0]                digit_seg [NUM_DIGITS];
  logic [6:0]                cur_seg;
  logic [6:0]                dec_in;
  logic                      dec_valid;
  logic [3:0]                dec_nibble;
  logic [CntW-1:0]           cnt_d;
  logic                      commit;
  logic                      timeout;
  logic                      advance;
  logic [NUM_DIGITS*4-1:0]   word_d;
  logic [NUM_DIGITS-1:0]     err_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign digit_seg[g] = seg_bus_i[7*g +: 7];
  end

  assign cur_seg = digit_seg[idx_q];

  // With a single required sample the commit happens on the load edge itself, so
  // the live sample must be decoded; otherwise prev_q equals the live sample at commit.
  assign dec_in = (StableMin == 1) ? cur_seg : prev_q;

  seg7_to_hex u_seg7_to_hex (
    .seg_i    (dec_in),
    .valid_o  (dec_valid),
    .nibble_o (dec_nibble)
  );

  // Stability counter: restart on entry or on a changed sample, saturate at CntMax.
  always_comb begin
    cnt_d = CntW'(1);
    if (!entry_q && (cur_seg == prev_q)) begin
      cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);
    end
  end

  assign commit = (state_q == StSample) && (cnt_d == CntMax);

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int unsigned TimeoutMin = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned TcntW      = $clog2(TimeoutMin + 1);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(TimeoutMin);

  logic [TcntW-1:0] tcnt_q;
  logic [TcntW-1:0] tcnt_d;

  // Per-digit elapsed-cycle count, starting at 1 on the digit's first sampling edge.
  always_comb begin
    tcnt_d = TcntW'(1);
    if (!entry_q) begin
      tcnt_d = (tcnt_q == TcntMax) ? TcntMax : tcnt_q + TcntW'(1);
    end
  end

  // Timeout counter register; idle outside SAMPLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
    end else if (state_q == StSample) begin
      tcnt_q <= tcnt_d;
    end else begin
      tcnt_q <= '0;
    end
  end

  assign timeout = (state_q == StSample) && (tcnt_d == TcntMax);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A commit takes priority over a coincident timeout.
  assign advance = commit | timeout;

  // Merge the current digit's result into the word and error mask.
  always_comb begin
    word_d = word_q;
    err_d  = err_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        word_d[4*i +: 4] = commit ? dec_nibble : 4'h0;
        err_d[i]         = commit ? ~dec_valid : 1'b1;
      end
    end
  end

  // Scan FSM with registered busy/done and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      entry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            word_q  <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            entry_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StSample;
          end
        end
        StSample: begin
          prev_q  <= cur_seg;
          cnt_q   <= cnt_d;
          entry_q <= 1'b0;
          if (advance) begin
            word_q  <= word_d;
            err_q   <= err_d;
            entry_q <= 1'b1;
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          entry_q <= 1'b0;
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word_o     = word_q;
  assign err_mask_o = err_q;

endmodule
